// File: rtl/cv32e40p_recovery_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_recovery_pkg
//
// Shared types for the register-file recovery sequencer:
//   recovery_state_e    : sequencer FSM states
//   RECOVERY_MAX_WPORTS : widest supported lane count
//   recovery_lane_t     : one lane's write beat (valid, addr, data) as seen
//                         by the core register file
// ----------------------------------------------------------------------------
package cv32e40p_recovery_pkg;

  localparam int RECOVERY_MAX_WPORTS = 4;

  // Register indices never exceed 63 (64-entry RF with FP registers folded in).
  localparam int RECOVERY_ADDR_W = 6;
  // cv32e40p is RV32: register words are 32 bits.
  localparam int RECOVERY_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COPY  = 3'd1,
    DRAIN = 3'd2,
    CSR   = 3'd3,
    PC    = 3'd4
  } recovery_state_e;

  typedef struct packed {
    logic                       valid;
    logic [RECOVERY_ADDR_W-1:0] addr;
    logic [RECOVERY_DATA_W-1:0] data;
  } recovery_lane_t;

endpackage

// File: rtl/cv32e40p_recovery_wr_lane.sv
// ----------------------------------------------------------------------------
// cv32e40p_recovery_wr_lane
//
// One write lane of the recovery sequencer. Registers the checkpoint read
// address issued this cycle; in the following cycle the checkpoint data
// arrives and is forwarded to the core RF together with that address.
//
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   issue_i       : an address is issued on this lane this cycle
//   addr_i        : issued address (one bit wider than the RF address)
//   rdata_i       : checkpoint data for the address issued last cycle
//   wr_o          : write beat to the core RF (valid = masked write enable)
// ----------------------------------------------------------------------------
module cv32e40p_recovery_wr_lane
  import cv32e40p_recovery_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH:0]   addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output recovery_lane_t        wr_o
);

  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  logic                valid_d, valid_q;
  logic [ADDR_WIDTH:0] addr_d, addr_q;
  logic                we;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = issue_i;
    addr_d  = '0;
    if (issue_i) begin
      addr_d = addr_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  // x0 is hardwired to zero, and the last beat may carry lanes past the end
  // of the register file when NUM_REGS is not a multiple of the lane count.
  assign we = valid_q && (addr_q != '0) && (addr_q < ADDR_LIMIT);

  always_comb begin
    wr_o       = '0;
    wr_o.valid = we;
    wr_o.addr  = RECOVERY_ADDR_W'(addr_q);
    // Gate data with valid so the RF data bus is quiet outside write beats.
    if (valid_q) begin
      wr_o.data = RECOVERY_DATA_W'(rdata_i);
    end
  end

endmodule

// File: rtl/cv32e40p_rf_recovery_seq.sv
// ----------------------------------------------------------------------------
// cv32e40p_rf_recovery_seq
//
// Restores cv32e40p architectural state from a checkpoint source: streams
// the register file through NUM_WPORTS parallel lanes, then strobes CSR
// recovery (if CSR_EN) and PC recovery.
//
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   recover_req_i  : start request, sampled only in IDLE
//   abort_i        : abandon a running sequence (no completion pulses)
//   busy_o         : sequence in progress (drives core recover_i)
//   done_o         : one-cycle completion pulse
//   src_raddr_o    : checkpoint read addresses, one per lane
//   src_rdata_i    : checkpoint data, valid one cycle after the address
//   rf_we_o/rf_waddr_o/rf_wdata_o : core RF write ports, one per lane
//   csr_recover_o  : one-cycle strobe loading the recovery CSRs
//   pc_recover_o   : one-cycle strobe to the core pc_recover_i
// ----------------------------------------------------------------------------
module cv32e40p_rf_recovery_seq
  import cv32e40p_recovery_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_WPORTS = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter bit CSR_EN     = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             recover_req_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NUM_WPORTS*ADDR_WIDTH-1:0] src_raddr_o,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] src_rdata_i,
  output logic [NUM_WPORTS-1:0]            rf_we_o,
  output logic [NUM_WPORTS*ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [NUM_WPORTS*DATA_WIDTH-1:0] rf_wdata_o,
  output logic                             csr_recover_o,
  output logic                             pc_recover_o
);

  // Base counter carries one extra bit so it cannot wrap at NUM_REGS = 64.
  localparam logic [ADDR_WIDTH:0] BASE_STEP = (ADDR_WIDTH+1)'(NUM_WPORTS);

  recovery_state_e                 state_d, state_q;
  logic [ADDR_WIDTH:0]             base_d, base_q;
  logic                            busy_d, busy_q;
  logic                            csr_d, csr_q;
  logic                            pc_d, pc_q;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] raddr_d, raddr_q;
  logic                            issue;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (recover_req_i) begin
          state_d = COPY;
          base_d  = '0;
        end
      end
      COPY: begin
        base_d = base_q + BASE_STEP;
        if (int'(base_q) + NUM_WPORTS >= NUM_REGS) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = CSR_EN ? CSR : PC;
      CSR:     state_d = PC;
      PC:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // lines up with the state it belongs to and an abort suppresses them.
  always_comb begin
    busy_d  = (state_d != IDLE);
    csr_d   = (state_d == CSR);
    pc_d    = (state_d == PC);
    raddr_d = '0;
    if (state_d == COPY) begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        raddr_d[p*ADDR_WIDTH +: ADDR_WIDTH] =
          ADDR_WIDTH'(base_d + (ADDR_WIDTH+1)'(p));
      end
    end
  end

  // NOTE: reset is synchronous; every flop here, including the address
  // registers, is cleared so all outputs read zero straight after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      busy_q  <= 1'b0;
      csr_q   <= 1'b0;
      pc_q    <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      csr_q   <= csr_d;
      pc_q    <= pc_d;
      raddr_q <= raddr_d;
    end
  end

  assign busy_o        = busy_q;
  assign csr_recover_o = csr_q;
  assign pc_recover_o  = pc_q;
  assign done_o        = pc_q;
  assign src_raddr_o   = raddr_q;

  // An abort in COPY must not leave a write beat in flight.
  assign issue = (state_q == COPY) && !abort_i;

  for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_lane
    recovery_lane_t lane_wr;

    cv32e40p_recovery_wr_lane #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .issue_i(issue),
      .addr_i (base_q + (ADDR_WIDTH+1)'(p)),
      .rdata_i(src_rdata_i[p*DATA_WIDTH +: DATA_WIDTH]),
      .wr_o   (lane_wr)
    );

    assign rf_we_o[p]                              = lane_wr.valid;
    assign rf_waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH]  = ADDR_WIDTH'(lane_wr.addr);
    assign rf_wdata_o[p*DATA_WIDTH +: DATA_WIDTH]  = DATA_WIDTH'(lane_wr.data);
  end

endmodule

// File: tb/tb_cv32e40p_rf_recovery_seq.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_rf_recovery_seq
//
// Three sequencer instances share one clock:
//   u_dut0 : defaults (32 regs, 2 lanes, CSR phase)
//   u_dut1 : 33 regs, 2 lanes, no CSR phase
//   u_dut2 : 64 regs, 1 lane, CSR phase
// Each has a checkpoint source that returns 0x1000 + address one cycle
// after the address. Cycle n is the interval after rising edge n; the
// request is sampled at edge 0 and outputs are sampled 1 ns after an edge.
// ----------------------------------------------------------------------------
module tb_cv32e40p_rf_recovery_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rstn, req, abort;

  logic        busy0, done0, csr0, pc0;
  logic [1:0]  we0;
  logic [11:0] raddr0, waddr0;
  logic [63:0] rdata0, wdata0;

  logic        busy1, done1, csr1, pc1;
  logic [1:0]  we1;
  logic [11:0] raddr1, waddr1;
  logic [63:0] rdata1, wdata1;

  logic        busy2, done2, csr2, pc2;
  logic [0:0]  we2;
  logic [5:0]  raddr2, waddr2;
  logic [31:0] rdata2, wdata2;

  cv32e40p_rf_recovery_seq u_dut0 (
    .clk_i(clk), .rst_ni(rstn[0]), .recover_req_i(req[0]), .abort_i(abort[0]),
    .busy_o(busy0), .done_o(done0), .src_raddr_o(raddr0), .src_rdata_i(rdata0),
    .rf_we_o(we0), .rf_waddr_o(waddr0), .rf_wdata_o(wdata0),
    .csr_recover_o(csr0), .pc_recover_o(pc0)
  );

  cv32e40p_rf_recovery_seq #(.NUM_REGS(33), .NUM_WPORTS(2), .CSR_EN(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rstn[1]), .recover_req_i(req[1]), .abort_i(abort[1]),
    .busy_o(busy1), .done_o(done1), .src_raddr_o(raddr1), .src_rdata_i(rdata1),
    .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
    .csr_recover_o(csr1), .pc_recover_o(pc1)
  );

  cv32e40p_rf_recovery_seq #(.NUM_REGS(64), .NUM_WPORTS(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rstn[2]), .recover_req_i(req[2]), .abort_i(abort[2]),
    .busy_o(busy2), .done_o(done2), .src_raddr_o(raddr2), .src_rdata_i(rdata2),
    .rf_we_o(we2), .rf_waddr_o(waddr2), .rf_wdata_o(wdata2),
    .csr_recover_o(csr2), .pc_recover_o(pc2)
  );

  // Checkpoint sources: data = 0x1000 + address, one cycle later.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      rdata0[p*32 +: 32] <= 32'h1000 + 32'(raddr0[p*6 +: 6]);
      rdata1[p*32 +: 32] <= 32'h1000 + 32'(raddr1[p*6 +: 6]);
    end
    rdata2 <= 32'h1000 + 32'(raddr2);
  end

  // Observation mux: selected instance, zero-extended to 4 lanes.
  int           sel;
  logic         obs_busy, obs_done, obs_csr, obs_pc;
  logic [3:0]   obs_we;
  logic [23:0]  obs_waddr, obs_raddr;
  logic [127:0] obs_wdata;

  always_comb begin
    obs_busy = 1'b0; obs_done = 1'b0; obs_csr = 1'b0; obs_pc = 1'b0;
    obs_we = '0; obs_waddr = '0; obs_raddr = '0; obs_wdata = '0;
    case (sel)
      0: begin
        obs_busy = busy0; obs_done = done0; obs_csr = csr0; obs_pc = pc0;
        obs_we[1:0] = we0; obs_waddr[11:0] = waddr0;
        obs_raddr[11:0] = raddr0; obs_wdata[63:0] = wdata0;
      end
      1: begin
        obs_busy = busy1; obs_done = done1; obs_csr = csr1; obs_pc = pc1;
        obs_we[1:0] = we1; obs_waddr[11:0] = waddr1;
        obs_raddr[11:0] = raddr1; obs_wdata[63:0] = wdata1;
      end
      default: begin
        obs_busy = busy2; obs_done = done2; obs_csr = csr2; obs_pc = pc2;
        obs_we[0] = we2[0]; obs_waddr[5:0] = waddr2;
        obs_raddr[5:0] = raddr2; obs_wdata[31:0] = wdata2;
      end
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen;
  int x0_seen;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control bits packed as {busy, csr, pc, done}.
  function automatic logic [3:0] ctl();
    return {obs_busy, obs_csr, obs_pc, obs_done};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " ctl"},   64'(ctl()),     64'h0);
    check({tag, " we"},    64'(obs_we),    64'h0);
    check({tag, " waddr"}, 64'(obs_waddr), 64'h0);
    check({tag, " raddr"}, 64'(obs_raddr), 64'h0);
    check({tag, " wdata"}, obs_wdata[63:0], 64'h0);
  endtask

  // Runs one sequence on instance `sel` starting from IDLE (request sampled
  // at the next edge) and checks every cycle from 1 through B+3+C against the
  // documented timing. Returns positioned in cycle B+3+C.
  task automatic run_seq(input int n, input int w, input int c, input bit hold,
                         input string name);
    int b;
    int last;
    logic [3:0] we_exp;
    logic [3:0] ctl_exp;
    int a;
    b    = (n + w - 1) / w;
    last = b + 2 + c;
    req[sel] = 1'b1;
    step();
    if (!hold) req[sel] = 1'b0;
    for (int cy = 1; cy <= last + 1; cy++) begin
      we_exp  = '0;
      ctl_exp = {cy <= last, (c == 1) && (cy == b + 2), cy == last, cy == last};
      check($sformatf("%s cyc%0d ctl", name, cy), 64'(ctl()), 64'(ctl_exp));
      for (int p = 0; p < w; p++) begin
        a = (cy - 2) * w + p;
        if (cy >= 2 && cy <= b + 1 && a != 0 && a < n) we_exp[p] = 1'b1;
        if (obs_we[p]) begin
          wr_seen++;
          if (obs_waddr[p*6 +: 6] == 6'd0) x0_seen++;
        end
      end
      check($sformatf("%s cyc%0d we", name, cy), 64'(obs_we), 64'(we_exp));
      for (int p = 0; p < w; p++) begin
        a = (cy - 2) * w + p;
        if (we_exp[p]) begin
          check($sformatf("%s cyc%0d waddr%0d", name, cy, p),
                64'(obs_waddr[p*6 +: 6]), 64'(a));
          check($sformatf("%s cyc%0d wdata%0d", name, cy, p),
                64'(obs_wdata[p*32 +: 32]), 64'(32'h1000 + a));
        end
      end
      if (cy <= last) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; req = '0; abort = '0; rstn = '0;
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check_quiet($sformatf("reset dut%0d", s));
    end
    rstn = 3'b111;
    step();

    // Default configuration: 19-cycle sequence, spot values from the plan.
    sel = 0;
    run_seq(32, 2, 1, 1'b0, "dflt");

    // 33 registers over 2 lanes, no CSR phase: overflow lane suppressed.
    sel = 1;
    run_seq(33, 2, 0, 1'b0, "r33");

    // Single lane, 64 registers: 63 writes, x0 never written.
    sel = 2;
    wr_seen = 0;
    x0_seen = 0;
    run_seq(64, 1, 1, 1'b0, "r64");
    check("r64 write count", 64'(wr_seen), 64'd63);
    check("r64 x0 writes", 64'(x0_seen), 64'd0);

    // Abort during cycle 5: idle with no write at cycle 6, no pulses after.
    sel = 0;
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    repeat (4) step();
    check("abort busy before", 64'(obs_busy), 64'd1);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("abort busy", 64'(obs_busy), 64'd0);
    check("abort we", 64'(obs_we), 64'd0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("abort quiet %0d", i), 64'(ctl()), 64'h0);
      step();
    end
    run_seq(32, 2, 1, 1'b0, "after abort");

    // Request held high: back-to-back sequences, busy low for the one cycle
    // after done_o, requests during busy ignored.
    run_seq(32, 2, 1, 1'b1, "held1");
    run_seq(32, 2, 1, 1'b1, "held2");
    req[0] = 1'b0;
    step();
    check("held idle busy", 64'(obs_busy), 64'd0);

    // Reset asserted during cycle 10: all outputs zero at cycle 11.
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    repeat (9) step();
    check("rst busy before", 64'(obs_busy), 64'd1);
    rstn[0] = 1'b0;
    step();
    rstn[0] = 1'b1;
    check_quiet("rst mid");
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst stays idle %0d", i), 64'(ctl()), 64'h0);
    end
    run_seq(32, 2, 1, 1'b0, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_recovery_seq.md
# cv32e40p_rf_recovery_seq

Parametrised recovery sequencer that restores a cv32e40p core's architectural state from a checkpoint source after a fault. It streams the register file through 1..N write ports, then strobes CSR and PC recovery. It sits beside `cv32e40p_core` and drives the core's `recover_i`, `regfile_we/waddr/wdata_*_i`, CSR recovery and `pc_recover_i` ports. It generalises the fixed two-port, externally sequenced recovery interface to a configurable port count, register count and optional CSR phase.

## Interface

Parameters:
- `NUM_REGS`, default 32: registers restored. Use 64 when the FP register file lives in the RF; legal range is 2..64.
- `NUM_WPORTS`, default 2: parallel read/write lanes. Legal range is 1..4.
- `ADDR_WIDTH`, default 6: register address width.
- `DATA_WIDTH`, default 32: register data width.
- `CSR_EN`, default 1: when 1, the CSR phase is included; when 0, it is skipped.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `recover_req_i` in 1: start request, level-sampled in IDLE.
- `abort_i` in 1: abandons an in-progress sequence.
- `busy_o` out 1: high while a sequence runs. The core holds `recover_i` from this.
- `done_o` out 1: one-cycle completion pulse.
- `src_raddr_o` out NUM_WPORTS x ADDR_WIDTH: checkpoint read addresses.
- `src_rdata_i` in NUM_WPORTS x DATA_WIDTH: checkpoint data, valid exactly 1 cycle after the address.
- `rf_we_o` out NUM_WPORTS: core RF write enables.
- `rf_waddr_o` out NUM_WPORTS x ADDR_WIDTH: core RF write addresses.
- `rf_wdata_o` out NUM_WPORTS x DATA_WIDTH: core RF write data.
- `csr_recover_o` out 1: one-cycle strobe loading the recovery CSRs.
- `pc_recover_o` out 1: one-cycle strobe to the core `pc_recover_i`.

## Operation

- FSM states: IDLE, COPY, DRAIN, CSR, PC.
- IDLE:
  - `recover_req_i`=1 goes to COPY and clears the base counter.
  - `recover_req_i` is ignored in every other state.
- COPY:
  - Lane p drives `src_raddr_o[p]` = base+p; base then advances by NUM_WPORTS.
  - When base+NUM_WPORTS ≥ NUM_REGS, go to DRAIN.
- Write pipeline: one register stage per lane. In the cycle after an address is issued:
  - `rf_waddr_o[p]` = the registered address.
  - `rf_wdata_o[p]` = `src_rdata_i[p]`.
  - `rf_we_o[p]` = valid AND address≠0 AND address<NUM_REGS.
  - Consequence: x0 is never written, and overflow lanes are suppressed when NUM_REGS is not a multiple of NUM_WPORTS.
- DRAIN: the final write beat completes. Then go to CSR if CSR_EN, else to PC.
- CSR: assert `csr_recover_o` for one cycle, then go to PC.
- PC: assert `pc_recover_o` and `done_o` for one cycle, then go to IDLE.
- `abort_i`:
  - Takes effect in any non-IDLE state; the next state is IDLE.
  - The pipeline valids are cleared, so no write is issued in the following cycle.
  - No `done_o`, `csr_recover_o` or `pc_recover_o` pulse is produced.
  - `abort_i` in IDLE has no effect. `abort_i` and `recover_req_i` together in IDLE start the sequence.
- `busy_o` = (state≠IDLE).
- Base counter width is ADDR_WIDTH+1, so it cannot wrap at NUM_REGS=64.

## Timing

- Reset: state IDLE; every output is 0, including `src_raddr_o`, `rf_waddr_o` and `rf_wdata_o`.
- Reset asserted mid-sequence: IDLE on the next edge, with no pulses.
- Definitions: request sampled at cycle 0, B = ceil(NUM_REGS/NUM_WPORTS), C = CSR_EN.
- `busy_o` is high for cycles 1..B+2+C.
- COPY occupies cycles 1..B.
- Writes for beat k (k=1..B) appear at cycle k+1. The last write is at cycle B+1 (DRAIN).
- `csr_recover_o` fires at cycle B+2 when C=1.
- `pc_recover_o` and `done_o` fire at cycle B+2+C.
- A new request is accepted no earlier than the cycle after `done_o`.
- Total latency is B+2+C cycles. Default configuration: 19 cycles.

## Structure

- Package `cv32e40p_recovery_pkg` holds:
  - the `recovery_state_e` enum (IDLE, COPY, DRAIN, CSR, PC);
  - `RECOVERY_MAX_WPORTS`=4;
  - the `recovery_lane_t` struct (valid, addr, data).
- Sub-module `cv32e40p_recovery_wr_lane`: one lane's pipeline register plus the x0/overflow write-enable masking, instantiated NUM_WPORTS times via generate.

## Test plan

- Defaults, request pulse at cycle 0, source returns data = 0x1000+addr.
  - Cycle 2: `rf_we_o`=2'b10, addr 1 = 0x1001.
  - Cycle 17: addrs 30/31 written.
  - `csr_recover_o` at cycle 18; `pc_recover_o`/`done_o` at cycle 19; `busy_o` low at cycle 20.
- NUM_REGS=33, NUM_WPORTS=2, CSR_EN=0.
  - B=17; at cycle 18 lane 1 (addr 33) is suppressed and addr 32 is written.
  - `done_o` at cycle 19; `csr_recover_o` never asserts.
- NUM_WPORTS=1, NUM_REGS=64.
  - 63 writes with addrs 1..63 in order; x0 is never written.
  - `done_o` at cycle 67.
- `abort_i` at cycle 5 of a default run.
  - Cycle 6: state IDLE, `busy_o`=0, `rf_we_o`=0.
  - No `done_o`, `csr_recover_o` or `pc_recover_o` pulse; a fresh request then completes normally.
- `recover_req_i` held high throughout.
  - Exactly one sequence per IDLE entry: the second starts the cycle after `done_o` (cycle 20).
  - Requests during busy are ignored.
- `rst_ni`=0 at cycle 10.
  - All outputs are 0 at cycle 11.
  - The sequence resumes only on a new request after reset is released.
